// File: rtl/zero_detect_ctrl.sv
// Shared equality/zero-detect unit for beq/bne resolution: two round-robin requesters,
// with one CHUNK-wide OR-reduction reused across cycles, LSB chunk first, exiting on the first nonzero chunk.
module zero_detect_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ne,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ne,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic             resp_zero,
  output logic             resp_taken,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               id_q, id_d;
  logic               ne_q, ne_d;
  logic [WIDTH-1:0]   diff_q, diff_d;

  logic               gnt0, gnt1;
  logic [CHUNK-1:0]   chunk;
  logic               hit;
  logic               in_done;

  // last_q names the previous winner, so on contention the other requester goes next.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  assign chunk = diff_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign hit   = |chunk;

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path leaves a latch.
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    id_d    = id_q;
    ne_d    = ne_q;
    diff_d  = diff_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          diff_d  = gnt1 ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
          ne_d    = gnt1 ? req1_ne : req0_ne;
          id_d    = gnt1;
          last_d  = gnt1;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          acc_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      id_q    <= 1'b0;
      ne_q    <= 1'b0;
      // NOTE: diff_q is rewritten on every accept; it is cleared only to keep reset state deterministic.
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      id_q    <= id_d;
      ne_q    <= ne_d;
      diff_q  <= diff_d;
    end
  end

  assign in_done    = (state_q == DONE);
  assign req0_ready = (state_q == IDLE) & gnt0 & ~rst;
  assign req1_ready = (state_q == IDLE) & gnt1 & ~rst;
  assign resp_valid = in_done;
  assign resp_id    = in_done & id_q;
  assign resp_zero  = in_done & ~acc_q;
  assign resp_taken = in_done & (ne_q ^ ~acc_q);
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/zero_detect_ctrl.md
# zero_detect_ctrl

Two-port, round-robin-arbitrated, multi-cycle equality/zero-detect controller for branch resolution (beq/bne) in the 32-bit MIPS core. It lets the branch unit and the ALU flag path share one time-multiplexed 8-bit OR-reduction slice. It XORs the two operands and scans the difference one chunk per cycle, stopping early on the first nonzero chunk. It then reports zero/taken on a valid/ready response port.

## Interface
- WIDTH, 32, operand width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits OR-reduced per scan cycle; WIDTH/CHUNK = NCHUNK (4 at defaults).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 (branch unit) has an operation.
- req0_a, req0_b  input  WIDTH  operands for requester 0.
- req0_ne  input  1  1 = bne semantics, 0 = beq semantics.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ne, req1_ready  same as above, for requester 1 (ALU flag path).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  which requester the result belongs to.
- resp_zero  output  1  1 when a == b (a^b is all zero).
- resp_taken  output  1  branch decision: ne ? ~resp_zero : resp_zero.
- busy  output  1  high in SCAN and DONE.

## Operation
- States: IDLE, SCAN, DONE. All registers are updated on clk.
- **IDLE**
  - Arbitration is round-robin on a `last` register. If both requesters are valid, the requester != last is granted. If only one is valid, it is granted.
  - reqN_ready = (state==IDLE) & granted_N & ~rst. This is combinational; at most one ready is high.
  - On accept:
    - diff <= a^b, ne_r <= ne, id_r <= N, last <= N.
    - cnt <= 0, acc <= 0.
    - Go to SCAN.
- **SCAN**
  - Each cycle: hit = |diff[cnt*CHUNK +: CHUNK]. Chunks are scanned from the LSB upward.
  - If hit: acc <= 1, go to DONE (early termination).
  - Else if cnt == NCHUNK-1: go to DONE with acc = 0.
  - Else: cnt <= cnt+1.
- **DONE**
  - Outputs: resp_valid = 1, resp_id = id_r, resp_zero = ~acc, resp_taken = ne_r ^ ~acc.
  - Outputs hold stable while resp_ready = 0.
  - On resp_valid & resp_ready, go to IDLE. No new request is accepted in that same cycle.
- In SCAN and DONE, reqN_ready = 0. A requester keeps valid asserted with stable operands until it sees ready.
- Reset:
  - State <= IDLE, last <= 1 (requester 0 wins the first contention), cnt <= 0, acc <= 0, id_r <= 0, ne_r <= 0.
  - Output reset values: req0_ready = req1_ready = 0 during reset, resp_valid = 0, resp_id = 0, resp_zero = 0, resp_taken = 0, busy = 0.
  - Reset mid-SCAN or mid-DONE abandons the operation; no response is produced for it.

## Timing
- Accept at edge E0 (valid & ready high in the cycle before E0). SCAN occupies the cycles after E0.
- Nonzero in chunk k (0-based, lowest nonzero chunk): resp_valid rises k+2 cycles after the accept cycle.
- Equal operands: resp_valid rises NCHUNK+1 cycles after the accept cycle (5 at defaults).
- Latency is independent of the ne bit.
- Minimum issue interval:
  - (k+2) + 1 cycles with resp_ready tied high: SCAN/DONE plus the IDLE accept cycle.
  - Equal operands at defaults: 6 cycles per operation.
- A requester dropping valid while not accepted is legal; the arbiter re-evaluates every IDLE cycle.

## Test plan
- **Reset values:** hold rst 3 cycles with both valids high -> both readys 0, resp_valid 0, busy 0. First IDLE cycle after reset: req0_ready = 1.
- **Equal beq:** req0 a = b = 32'hDEADBEEF, ne = 0 -> resp_valid 5 cycles after accept, resp_zero = 1, resp_taken = 1, resp_id = 0.
- **Early exit, bne:** req1 a = 32'h0000_0001, b = 0, ne = 1 -> resp_valid 2 cycles after accept, resp_zero = 0, resp_taken = 1, resp_id = 1.
- **Top-chunk difference:** a = 32'h8000_0000, b = 0, ne = 0 -> resp_valid 5 cycles after accept, resp_zero = 0, resp_taken = 0.
- **Round-robin and backpressure:**
  - Both requesters valid continuously with resp_ready = 0 for 3 cycles in DONE.
  - Required: grant order 0, 1, 0, 1.
  - DONE outputs stay stable while stalled; no ready is asserted while busy.
- **Reset mid-SCAN:** assert rst 2 cycles after accept -> no response appears, next IDLE grants requester 0, and the subsequent op completes correctly.
